fifo_write_ctrl: RTL and testbench
==================================

# fifo_write_ctrl

Write-domain controller for the asynchronous FIFO in the I2C data path. It generalises the write-side pointer logic with a configurable synchroniser depth, a binary fill level, a programmable almost-full threshold and a sticky overflow flag. It sits between the write-side client and the dual-port FIFO memory. It takes the raw Gray read pointer from the read domain and exports the Gray write pointer to the read-side controller.

## Interface
- ADDR_SIZE, 3, address width; depth DEPTH = 2**ADDR_SIZE; pointers are ADDR_SIZE+1 bits.
- SYNC_STAGES, 2, flop stages synchronising the read pointer (legal ≥ 2).
- write_clock_i  in  1  write-domain clock.
- write_reset_n_i  in  1  reset, asynchronous, active-low.
- write_inc_i  in  1  write request; accepted when write_full_o = 0.
- read_gray_ptr_i  in  ADDR_SIZE+1  Gray read pointer, asynchronous to write_clock_i.
- almost_full_level_i  in  ADDR_SIZE+1  almost-full threshold; 0 disables the flag.
- write_overflow_clear_i  in  1  clears the sticky overflow flag.
- write_addr_o  out  ADDR_SIZE  memory write address (binary, low bits).
- write_pointer_o  out  ADDR_SIZE+1  registered Gray write pointer to the read domain.
- write_full_o  out  1  FIFO full.
- write_almost_full_o  out  1  level ≥ threshold.
- write_level_o  out  ADDR_SIZE+1  fill level, 0..DEPTH, as seen from the write domain.
- write_overflow_o  out  1  sticky; a write was attempted while full.

## Operation
- accept = write_inc_i & ~write_full_o; binary pointer wb_next = wb + accept (mod 2·DEPTH); write_pointer_o <= bin2gray(wb_next).
- write_addr_o = wb[ADDR_SIZE-1:0] (combinational from the registered pointer); the memory writes at this address when accept = 1.
- Read pointer: read_gray_ptr_i passes through the SYNC_STAGES flop chain, then gray2bin gives rb_sync.
- level_next = wb_next − rb_sync, computed modulo 2**(ADDR_SIZE+1), which is always 0..DEPTH.
- Registered flags:
  - write_full_o <= (level_next == DEPTH).
  - write_almost_full_o <= (almost_full_level_i != 0) & (level_next ≥ almost_full_level_i).
  - write_level_o <= level_next.
- Level is pessimistic. The stale read pointer can only overstate occupancy, so no write is ever accepted into a full FIFO.
- Overflow: write_inc_i & write_full_o sets write_overflow_o. write_overflow_clear_i clears it. If set and clear occur in the same cycle, set wins. The rejected write changes no pointer.
- Threshold values above DEPTH never assert almost-full.
- Wrap-around: the pointer MSB toggles on each pass of DEPTH entries. write_addr_o wraps DEPTH−1 → 0 with no gap.

## Timing
- Reset, asynchronous: wb, write_pointer_o, the sync chain, write_level_o, write_full_o, write_almost_full_o and write_overflow_o all go to 0 immediately. write_addr_o = 0.
- A write accepted in cycle n appears in write_pointer_o, write_level_o and the flags at edge n+1.
- Full asserts on the same edge as the accepted write that fills the FIFO. A write_inc_i in the next cycle is rejected.
- A read-pointer change reaches level and flags after SYNC_STAGES+1 write-clock edges. This covers SYNC_STAGES sync flops plus the flag register.
- A simultaneous accepted write and a synchronised read-pointer advance leave the level unchanged.
- Reset asserted mid-operation discards all state; the FIFO is empty after release.

## Configuration
- WRITE_OVERFLOW_EN:
  - Defined: the sticky overflow flop and write_overflow_clear_i logic are compiled in.
  - Undefined: write_overflow_o is tied to 0, write_overflow_clear_i is ignored, and no overflow flop exists.
  - Pointer behaviour is identical in both cases.

## Structure
- Package fifo_pkg holds:
  - bin2gray and gray2bin functions (width-generic via ADDR_SIZE).
  - the DEPTH derivation.
  - shared by the read-side controller.
- Sub-module gray_sync holds the parametrised SYNC_STAGES-deep multi-bit synchroniser for Gray pointers (async reset to 0). It is reused by the read side.

## Test plan
(ADDR_SIZE=3, SYNC_STAGES=2)
- Reset → write_addr_o=0, write_pointer_o=4'b0000, write_level_o=0, all flags 0; reassert reset mid-burst → outputs return to 0 without a clock edge.
- read_gray_ptr_i held 0, 8 back-to-back writes → after the 8th edge write_level_o=8, write_full_o=1, write_pointer_o=4'b1100, write_addr_o=0.
- While full, write_inc_i=1 one cycle → pointer unchanged and write_overflow_o=1. Pulse clear → 0. Set and clear in the same cycle → stays 1.
- almost_full_level_i=6, writes from empty → write_almost_full_o rises on the edge after the 6th write, level=6. With almost_full_level_i=0 it never asserts.
- FIFO full, read_gray_ptr_i steps to 4'b0110 (binary 4) → 3 edges later write_full_o=0, write_level_o=4. A write in that cycle is accepted.
- 20 writes with the read pointer trailing by 2 → write_addr_o wraps 7→0, pointer MSB toggles at binary 8, level stays at most 2 + sync lag, and full never asserts.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: definitions shared by the write-side and read-side FIFO controllers.
//   depth_of  : FIFO depth for a given address width (2**addr_size).
//   bin2gray  : binary to Gray conversion on a zero-extended pointer.
//   gray2bin  : Gray to binary conversion on a zero-extended pointer.
// The conversions work on a wide container type. Callers zero-extend their
// ADDR_SIZE+1 bit pointer into it and truncate the result back. Leading zeros
// map to leading zeros in both directions, so one function serves every
// pointer width up to PTR_MAX_W.
package fifo_pkg;

  localparam int PTR_MAX_W = 16;

  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  function automatic int unsigned depth_of(input int unsigned addr_size);
    return 32'd1 << addr_size;
  endfunction

  function automatic ptr_max_t bin2gray(input ptr_max_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_max_t gray2bin(input ptr_max_t gray);
    ptr_max_t bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// gray_sync: STAGES-deep flop chain that brings a Gray-coded pointer into the
// local clock domain. Only one bit of a Gray pointer changes per step, so
// sampling the bus as a whole yields either the old or the new value.
//   clock     in  local clock
//   reset_n   in  asynchronous active-low reset; clears every stage to 0
//   async_in  in  WIDTH-bit Gray pointer from the other domain
//   sync_out  out WIDTH-bit synchronised pointer (last stage)
module gray_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) begin
        chain[i] <= '0;
      end
    end else begin
      chain[0] <= async_in;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/fifo_write_ctrl.sv
// fifo_write_ctrl: write-domain controller of the asynchronous FIFO.
// Keeps the binary write pointer, exports its Gray form to the read side,
// synchronises the read pointer and derives a registered fill level,
// full and almost-full flags, and an optional sticky overflow flag.
// Optional feature macro: WRITE_OVERFLOW_EN (sticky overflow flag and its
// clear input; when undefined write_overflow_o is tied low).
//   write_clock_i          in  write-domain clock
//   write_reset_n_i        in  asynchronous active-low reset
//   write_inc_i            in  write request, accepted while not full
//   read_gray_ptr_i        in  Gray read pointer from the read domain
//   almost_full_level_i    in  almost-full threshold, 0 disables the flag
//   write_overflow_clear_i in  clears the sticky overflow flag
//   write_addr_o           out memory write address
//   write_pointer_o        out registered Gray write pointer
//   write_full_o           out FIFO full
//   write_almost_full_o    out level >= threshold
//   write_level_o          out fill level 0..DEPTH seen from the write side
//   write_overflow_o       out sticky: write attempted while full
module fifo_write_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE   = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 write_clock_i,
  input  logic                 write_reset_n_i,
  input  logic                 write_inc_i,
  input  logic [ADDR_SIZE:0]   read_gray_ptr_i,
  input  logic [ADDR_SIZE:0]   almost_full_level_i,
  input  logic                 write_overflow_clear_i,
  output logic [ADDR_SIZE-1:0] write_addr_o,
  output logic [ADDR_SIZE:0]   write_pointer_o,
  output logic                 write_full_o,
  output logic                 write_almost_full_o,
  output logic [ADDR_SIZE:0]   write_level_o,
  output logic                 write_overflow_o
);

  localparam int PTR_W = ADDR_SIZE + 1;
  localparam int DEPTH = depth_of(ADDR_SIZE);
  localparam logic [PTR_W-1:0] DEPTH_PTR = PTR_W'(DEPTH);

  logic [PTR_W-1:0] wb;
  logic [PTR_W-1:0] wb_next;
  logic [PTR_W-1:0] read_gray_sync;
  logic [PTR_W-1:0] rb_sync;
  logic [PTR_W-1:0] level_next;
  logic             accept;

  gray_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_read_sync (
    .clock    (write_clock_i),
    .reset_n  (write_reset_n_i),
    .async_in (read_gray_ptr_i),
    .sync_out (read_gray_sync)
  );

  assign accept  = write_inc_i & ~write_full_o;
  assign wb_next = wb + PTR_W'(accept);
  assign rb_sync = PTR_W'(gray2bin(ptr_max_t'(read_gray_sync)));

  // Modulo subtraction against a read pointer that can only lag the real
  // one, so the level never understates occupancy.
  assign level_next = wb_next - rb_sync;

  assign write_addr_o = wb[ADDR_SIZE-1:0];

  always_ff @(posedge write_clock_i or negedge write_reset_n_i) begin
    if (!write_reset_n_i) begin
      wb                  <= '0;
      write_pointer_o     <= '0;
      write_level_o       <= '0;
      write_full_o        <= 1'b0;
      write_almost_full_o <= 1'b0;
    end else begin
      wb                  <= wb_next;
      write_pointer_o     <= PTR_W'(bin2gray(ptr_max_t'(wb_next)));
      write_level_o       <= level_next;
      write_full_o        <= (level_next == DEPTH_PTR);
      write_almost_full_o <= (almost_full_level_i != '0) &&
                             (level_next >= almost_full_level_i);
    end
  end

`ifdef WRITE_OVERFLOW_EN
  // Set has priority over clear so a rejected write is never lost.
  always_ff @(posedge write_clock_i or negedge write_reset_n_i) begin
    if (!write_reset_n_i) begin
      write_overflow_o <= 1'b0;
    end else if (write_inc_i && write_full_o) begin
      write_overflow_o <= 1'b1;
    end else if (write_overflow_clear_i) begin
      write_overflow_o <= 1'b0;
    end
  end
`else
  logic unused_overflow_clear;
  assign unused_overflow_clear = write_overflow_clear_i;
  assign write_overflow_o      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_write_ctrl.sv
module tb_fifo_write_ctrl;

`ifdef WRITE_OVERFLOW_EN
  localparam int OV_EN = 1;
`else
  localparam int OV_EN = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       inc;
  logic [3:0] rptr;
  logic [3:0] af_level;
  logic       ov_clear;
  logic [2:0] addr;
  logic [3:0] wptr;
  logic       full;
  logic       afull;
  logic [3:0] level;
  logic       ov;

  int n_checks;
  int n_pass;

  fifo_write_ctrl #(
    .ADDR_SIZE   (3),
    .SYNC_STAGES (2)
  ) dut (
    .write_clock_i          (clk),
    .write_reset_n_i        (rst_n),
    .write_inc_i            (inc),
    .read_gray_ptr_i        (rptr),
    .almost_full_level_i    (af_level),
    .write_overflow_clear_i (ov_clear),
    .write_addr_o           (addr),
    .write_pointer_o        (wptr),
    .write_full_o           (full),
    .write_almost_full_o    (afull),
    .write_level_o          (level),
    .write_overflow_o       (ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int gray(input int x);
    return (x ^ (x >> 1)) & 15;
  endfunction

  initial begin
    int af_seen;
    int rp;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    inc      = 1'b0;
    rptr     = 4'd0;
    af_level = 4'd6;
    ov_clear = 1'b0;

    // reset state
    tick();
    tick();
    check("rst_addr", addr, 0);
    check("rst_ptr", wptr, 0);
    check("rst_level", level, 0);
    check("rst_full", full, 0);
    check("rst_afull", afull, 0);
    check("rst_ov", ov, 0);
    rst_n = 1'b1;
    tick();

    // fill from empty with threshold 6, read pointer held at 0
    inc = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("fill_level_%0d", i), level, i);
      check($sformatf("fill_afull_%0d", i), afull, (i >= 6) ? 1 : 0);
      check($sformatf("fill_full_%0d", i), full, (i == 8) ? 1 : 0);
    end
    inc = 1'b0;
    check("full_ptr", wptr, 4'b1100);
    check("full_addr", addr, 0);

    // rejected write while full
    inc = 1'b1;
    tick();
    inc = 1'b0;
    check("ovw_ptr", wptr, 4'b1100);
    check("ovw_level", level, 8);
    check("ovw_ov", ov, OV_EN);
    ov_clear = 1'b1;
    tick();
    check("ov_clear", ov, 0);
    inc = 1'b1;
    tick();
    inc      = 1'b0;
    ov_clear = 1'b0;
    check("ov_set_wins", ov, OV_EN);
    ov_clear = 1'b1;
    tick();
    ov_clear = 1'b0;
    check("ov_clear2", ov, 0);

    // read pointer advances to binary 4
    rptr = 4'b0110;
    tick();
    check("rd_e1_full", full, 1);
    tick();
    check("rd_e2_full", full, 1);
    check("rd_e2_level", level, 8);
    tick();
    check("rd_e3_full", full, 0);
    check("rd_e3_level", level, 4);
    inc = 1'b1;
    tick();
    check("rd_wr_level", level, 5);
    check("rd_wr_addr", addr, 1);
    check("rd_wr_ptr", wptr, 4'b1101);
    tick();
    check("rd_wr_afull", afull, 1);

    // asynchronous reset mid-burst, no clock edge in between
    rst_n = 1'b0;
    #2;
    check("mid_rst_ptr", wptr, 0);
    check("mid_rst_addr", addr, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_full", full, 0);
    check("mid_rst_afull", afull, 0);
    inc  = 1'b0;
    rptr = 4'd0;
    tick();
    rst_n = 1'b1;
    tick();

    // threshold 0 disables almost-full
    af_level = 4'd0;
    af_seen  = 0;
    inc      = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (afull) af_seen = 1;
    end
    inc = 1'b0;
    check("af0_never", af_seen, 0);
    check("af0_full", full, 1);
    check("af0_level", level, 8);

    // wrap-around with the read pointer trailing the writes by 2
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    inc = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      rp   = (e >= 3) ? ((e - 3) & 15) : 0;
      rptr = 4'(gray(rp));
      tick();
      check($sformatf("wrap_addr_%0d", e), addr, e % 8);
      check($sformatf("wrap_ptr_%0d", e), wptr, gray(e % 16));
      check($sformatf("wrap_level_%0d", e), level, (e < 5) ? e : 5);
      check($sformatf("wrap_full_%0d", e), full, 0);
    end
    inc = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
